// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  display_pkg
//  Shared types and constants for the multiplexed 7-segment scan driver.
//  Revision: 1.0
// ============================================================================
package display_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] DISP_OFF_ACTIVE_LOW  = 7'h7F;
    localparam logic [6:0] DISP_OFF_ACTIVE_HIGH = 7'h00;
    localparam logic       SEG_OFF_ACTIVE_LOW   = 1'b1;
    localparam logic       SEG_OFF_ACTIVE_HIGH  = 1'b0;

    function automatic logic [6:0] apply_polarity(input logic [6:0] pat,
                                                  input logic       active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  scan_tick_gen
//  Per-digit slot counter with end-of-blank and end-of-slot strobes.
//  Revision: 1.0
// ============================================================================
module scan_tick_gen #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blank_end,
    output logic slot_end
);

    localparam int                C_CNT_W      = $clog2(SCAN_DIV);
    localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_SLOT_LAST  = C_CNT_W'(SCAN_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_ONE        = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_count;
    logic               w_at_slot_last;

    assign w_at_slot_last = (r_count == C_SLOT_LAST);
    // Strobes are qualified by en so a frozen scan never advances the FSM.
    assign blank_end      = en && (r_count == C_BLANK_LAST);
    assign slot_end       = en && w_at_slot_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_at_slot_last ? '0 : (r_count + C_ONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
//  display_scan_driver
//  Time-multiplexed 7-segment scan with per-slot blanking and digit blink.
//  Revision: 1.0
// ============================================================================
module display_scan_driver
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  En,
    input  logic [7*DIGITS-1:0]   digits_in,
    input  logic                  blink_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            display,
    output logic [DIGITS-1:0]     segment,
    output logic                  frame_done,
    output logic                  blink_phase
);

    localparam int                 C_IDX_W    = $clog2(DIGITS);
    localparam int                 C_FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(DIGITS - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE  = C_IDX_W'(1);
    localparam logic [C_FRM_W-1:0] C_FRM_LAST = C_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [C_FRM_W-1:0] C_FRM_ONE  = C_FRM_W'(1);
    localparam logic               C_ACT_LOW  = (ACTIVE_LOW != 0);
    localparam logic [6:0]         C_DISP_OFF = C_ACT_LOW ? DISP_OFF_ACTIVE_LOW
                                                          : DISP_OFF_ACTIVE_HIGH;
    localparam logic [DIGITS-1:0]  C_SEG_OFF  = C_ACT_LOW ? {DIGITS{SEG_OFF_ACTIVE_LOW}}
                                                          : {DIGITS{SEG_OFF_ACTIVE_HIGH}};

    scan_state_t          r_state, w_state_nxt;
    logic [C_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [C_FRM_W-1:0]   r_frame, w_frame_nxt;
    logic                 r_blink_phase, w_phase_nxt;
    logic [6:0]           r_pattern, w_pattern_nxt;
    logic [6:0]           r_display, w_display_nxt;
    logic [DIGITS-1:0]    r_segment, w_segment_nxt;
    logic                 r_frame_done, w_frame_done_nxt;

    logic                 w_blank_end;
    logic                 w_slot_end;
    logic [6:0]           w_sel_pattern;
    logic [DIGITS-1:0]    w_onehot;
    logic                 w_mask_bit;
    logic                 w_blink_dark;

    scan_tick_gen #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk       (Clk),
        .rst       (Clr),
        .en        (En),
        .blank_end (w_blank_end),
        .slot_end  (w_slot_end)
    );

    // Compare-based selection keeps non-power-of-two DIGITS safe from out-of-range indexing.
    always_comb begin
        w_sel_pattern = '0;
        w_onehot      = '0;
        w_mask_bit    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == C_IDX_W'(i)) begin
                w_sel_pattern = digits_in[7*i +: 7];
                w_onehot[i]   = 1'b1;
                w_mask_bit    = blink_mask[i];
            end
        end
    end

    assign w_blink_dark = blink_en & w_mask_bit & r_blink_phase;

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_frame_nxt      = r_frame;
        w_phase_nxt      = r_blink_phase;
        w_pattern_nxt    = r_pattern;
        w_display_nxt    = C_DISP_OFF;
        w_segment_nxt    = C_SEG_OFF;
        w_frame_done_nxt = 1'b0;

        if (En) begin
            case (r_state)
                ST_BLANK: begin
                    if (w_blank_end) begin
                        w_state_nxt   = ST_SHOW;
                        w_pattern_nxt = w_sel_pattern;
                    end
                end
                ST_SHOW: begin
                    if (w_slot_end) begin
                        w_state_nxt = ST_BLANK;
                        if (r_idx == C_IDX_LAST) begin
                            w_idx_nxt        = '0;
                            w_frame_done_nxt = 1'b1;
                            if (r_frame == C_FRM_LAST) begin
                                w_frame_nxt = '0;
                                w_phase_nxt = ~r_blink_phase;
                            end else begin
                                w_frame_nxt = r_frame + C_FRM_ONE;
                            end
                        end else begin
                            w_idx_nxt = r_idx + C_IDX_ONE;
                        end
                    end
                end
                default: w_state_nxt = ST_BLANK;
            endcase

            // Outputs are registered from the next state so the on-window starts
            // exactly BLANK_CYCLES clocks into the slot.
            if (w_state_nxt == ST_SHOW) begin
                w_display_nxt = apply_polarity(w_pattern_nxt, C_ACT_LOW);
                if (!w_blink_dark) begin
                    w_segment_nxt = w_onehot ^ C_SEG_OFF;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state       <= ST_BLANK;
            r_idx         <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
            r_pattern     <= '0;
            r_display     <= C_DISP_OFF;
            r_segment     <= C_SEG_OFF;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frame       <= w_frame_nxt;
            r_blink_phase <= w_phase_nxt;
            r_pattern     <= w_pattern_nxt;
            r_display     <= w_display_nxt;
            r_segment     <= w_segment_nxt;
            r_frame_done  <= w_frame_done_nxt;
        end
    end

    assign display     = r_display;
    assign segment     = r_segment;
    assign frame_done  = r_frame_done;
    assign blink_phase = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
//  tb_display_scan_driver
//  Directed self-checking bench: DIGITS=4, SCAN_DIV=16, BLANK=2, BLINK_FRAMES=2.
//  Revision: 1.0
// ============================================================================
module tb_display_scan_driver;

    logic        Clk;
    logic        Clr;
    logic        En;
    logic [27:0] digits_in;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic [6:0]  display;
    logic [3:0]  segment;
    logic        frame_done;
    logic        blink_phase;

    int vectors;
    int miscompares;
    int cyc;
    int fd_hits;
    int lit;

    display_scan_driver #(
        .DIGITS       (4),
        .SCAN_DIV     (16),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .En          (En),
        .digits_in   (digits_in),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .display     (display),
        .segment     (segment),
        .frame_done  (frame_done),
        .blink_phase (blink_phase)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle t = state after the t-th rising edge since Clr release, sampled on the falling edge.
    task automatic run_to(input int t);
        while (cyc < t) begin
            @(negedge Clk);
            cyc++;
            if (frame_done) fd_hits++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        fd_hits     = 0;
        Clr         = 1'b1;
        En          = 1'b1;
        blink_en    = 1'b0;
        blink_mask  = 4'b0000;
        digits_in   = {7'h4F, 7'h5B, 7'h06, 7'h3F};

        repeat (3) @(negedge Clk);
        chk("rst_display", display, 7'h7F);
        chk("rst_segment", segment, 4'hF);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_blink_phase", blink_phase, 1'b0);

        // Reset release and first slot
        Clr = 1'b0;
        cyc = 0;
        fd_hits = 0;
        chk("t0_segment", segment, 4'hF);
        run_to(1);
        chk("t1_segment", segment, 4'hF);
        chk("t1_display", display, 7'h7F);
        run_to(2);
        chk("t2_segment", segment, 4'hE);
        chk("t2_display", display, 7'h40);
        run_to(15);
        chk("t15_segment", segment, 4'hE);
        run_to(16);
        chk("t16_blank_segment", segment, 4'hF);
        chk("t16_blank_display", display, 7'h7F);

        // Scan order, with digit 1 rewritten mid-SHOW
        run_to(18);
        chk("d1_segment", segment, 4'hD);
        chk("d1_display", display, 7'h79);
        run_to(20);
        digits_in[13:7] = 7'h77;
        run_to(25);
        chk("d1_latched_t25", display, 7'h79);
        run_to(31);
        chk("d1_latched_t31", display, 7'h79);
        run_to(34);
        chk("d2_segment", segment, 4'hB);
        chk("d2_display", display, 7'h24);
        run_to(50);
        chk("d3_segment", segment, 4'h7);
        chk("d3_display", display, 7'h30);
        run_to(63);
        chk("frame_done_quiet", fd_hits, 0);
        run_to(64);
        chk("frame_done_t64", frame_done, 1'b1);
        chk("frame_wrap_segment", segment, 4'hF);
        run_to(65);
        chk("frame_done_t65", frame_done, 1'b0);
        run_to(82);
        chk("d1_new_pattern", display, 7'h08);

        // Blink on digit 2
        run_to(90);
        blink_en   = 1'b1;
        blink_mask = 4'b0100;
        run_to(98);
        chk("blink_d2_lit", segment, 4'hB);
        run_to(127);
        chk("phase_t127", blink_phase, 1'b0);
        run_to(128);
        chk("phase_t128", blink_phase, 1'b1);
        run_to(146);
        chk("blink_d1_unaffected", segment, 4'hD);
        run_to(162);
        chk("blink_d2_dark", segment, 4'hF);
        chk("blink_d2_display", display, 7'h24);
        run_to(178);
        chk("blink_d3_unaffected", segment, 4'h7);
        run_to(255);
        chk("phase_t255", blink_phase, 1'b1);
        run_to(256);
        chk("phase_t256", blink_phase, 1'b0);
        run_to(290);
        chk("blink_d2_relit", segment, 4'hB);
        blink_en = 1'b0;

        // En freeze inside digit 3's SHOW (slot starts at 304)
        lit = 0;
        for (int t = 304; t <= 332; t++) begin
            run_to(t);
            if (t <= 329 && segment == 4'h7) lit++;
            if (t == 310) begin
                chk("pre_freeze_segment", segment, 4'h7);
                En = 1'b0;
            end
            if (t == 311) begin
                chk("freeze_segment", segment, 4'hF);
                chk("freeze_display", display, 7'h7F);
            end
            if (t == 320) begin
                chk("freeze_end_segment", segment, 4'hF);
                chk("freeze_frame_done", frame_done, 1'b0);
                En = 1'b1;
            end
            if (t == 321) begin
                chk("resume_segment", segment, 4'h7);
                chk("resume_display", display, 7'h30);
            end
            if (t == 329) chk("resume_last_on", segment, 4'h7);
            if (t == 330) chk("resume_frame_done", frame_done, 1'b1);
            if (t == 332) chk("resume_next_digit", segment, 4'hE);
        end
        chk("freeze_lit_cycles", lit, 14);

        // Async Clr mid-SHOW of digit 2 while blink_phase is 1
        run_to(430);
        chk("pre_clr_segment", segment, 4'hB);
        chk("pre_clr_phase", blink_phase, 1'b1);
        Clr = 1'b1;
        #1;
        chk("async_clr_segment", segment, 4'hF);
        chk("async_clr_display", display, 7'h7F);
        chk("async_clr_phase", blink_phase, 1'b0);
        repeat (2) @(negedge Clk);
        Clr = 1'b0;
        cyc = 0;
        fd_hits = 0;
        run_to(1);
        chk("restart_t1_segment", segment, 4'hF);
        run_to(2);
        chk("restart_t2_segment", segment, 4'hE);
        chk("restart_t2_display", display, 7'h40);
        run_to(64);
        chk("restart_frame_done", frame_done, 1'b1);
        chk("restart_phase_t64", blink_phase, 1'b0);
        run_to(128);
        chk("restart_phase_t128", blink_phase, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scan_driver.md
# display_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It takes pre-decoded segment patterns for `DIGITS` digits and scans them one at a time onto a shared segment bus. Each digit slot has a programmable blanking interval for ghost suppression, and individual digits can blink at a frame-derived rate. It sits between the display module and the board pins, and replaces the fixed 4-digit counter/decoder/mux scan chain.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, 2..8.
- `SCAN_DIV`, default 50000: clocks per digit slot, ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, default 64: clocks at the start of each slot with all anodes off, ≥ 1.
- `BLINK_FRAMES`, default 64: full scan frames per blink half-period, ≥ 1.
- `ACTIVE_LOW`, default 1: 1 inverts `display` and `segment` (off = 1); 0 makes them active-high.

Ports:
- `Clk`, in, 1: system clock; all state changes on its rising edge.
- `Clr`, in, 1: asynchronous, active-high reset.
- `En`, in, 1: scan enable.
- `digits_in`, in, 7*`DIGITS`: pattern for digit i is at `[7*i +: 7]`. Bit 0 is segment a, bit 6 is segment g; 1 = lit before polarity is applied.
- `blink_en`, in, 1: global blink enable.
- `blink_mask`, in, `DIGITS`: bit i set makes digit i blink.
- `display`, out, 7: shared segment bus, polarity per `ACTIVE_LOW`.
- `segment`, out, `DIGITS`: anode selects, polarity per `ACTIVE_LOW`; at most one is active.
- `frame_done`, out, 1: one-cycle pulse when the scan wraps from digit `DIGITS`-1 to digit 0.
- `blink_phase`, out, 1: 0 = blinking digits visible; 1 = blinking digits dark.

## Operation
State machine states: BLANK and SHOW. Internal registers:
- slot counter, 0..`SCAN_DIV`-1
- digit index, 0..`DIGITS`-1
- frame counter, 0..`BLINK_FRAMES`-1
- `blink_phase`
- latched pattern, 7 bits

Reset values:
- state = BLANK; slot counter, digit index and frame counter = 0; `blink_phase` = 0; `frame_done` = 0.
- `display` and `segment` are driven to the all-off level: all 1s when `ACTIVE_LOW`=1, all 0s otherwise.

BLANK:
- All anodes off; `display` off.
- Leaves when the slot counter equals `BLANK_CYCLES`-1.
- On that same edge, the latched pattern loads `digits_in[7*idx +: 7]`, and the state moves to SHOW.

SHOW:
- `display` = latched pattern, with polarity applied.
- `segment[idx]` is active unless `blink_en` & `blink_mask[idx]` & `blink_phase`; in that case all anodes stay off.
- When the slot counter equals `SCAN_DIV`-1: the counter returns to 0, the state returns to BLANK, and idx increments, wrapping from `DIGITS`-1 to 0.
- On the wrap, `frame_done` pulses, and the frame counter increments.
- When the frame counter wraps from `BLINK_FRAMES`-1 to 0, `blink_phase` toggles.

Other rules:
- Changes to `digits_in` during SHOW have no effect until the next latch. No tearing within a slot.
- `blink_mask` and `blink_en` are sampled combinationally into the registered anode output each cycle, so a change takes effect one clock later.
- `En`=0: all counters and the state freeze. Outputs are forced off on the next edge and `frame_done` is 0. On `En`=1, the scan resumes from the frozen state. The first SHOW cycle after resuming uses the already-latched pattern.
- `Clr` mid-slot aborts the slot immediately (asynchronously) and returns all outputs to their reset values.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Slot length is exactly `SCAN_DIV` clocks: `BLANK_CYCLES` off, then `SCAN_DIV`-`BLANK_CYCLES` on.
- Frame length is `DIGITS`*`SCAN_DIV` clocks. The blink period is 2*`BLINK_FRAMES` frames.
- The first anode becomes active `BLANK_CYCLES` clocks after `Clr` deasserts, with `En`=1.
- `frame_done` is high for exactly the first cycle of digit 0's BLANK.
- Counter widths are `$clog2` of each counter's range. No overflow is possible given the parameter constraints.

## Structure
- Shared package `display_pkg` holds:
  - the state enum (BLANK, SHOW)
  - the seven segment bit-position constants (`SEG_A` through `SEG_G`)
  - the all-off constants for each polarity
- One sub-module, `scan_tick_gen`: the slot counter, producing `blank_end` and `slot_end` strobes, with an `En` hold.
- The top level holds the FSM, the digit index, blink logic and output registers.

## Test plan
Unless stated otherwise, benches use `DIGITS`=4, `SCAN_DIV`=16, `BLANK_CYCLES`=2, `BLINK_FRAMES`=2, `ACTIVE_LOW`=1.

1. Reset and first slot: release `Clr` with `En`=1 and `digits_in`=0x…7F. Required response:
   - `segment`=4'b1111 and `display`=7'h7F for 2 clocks;
   - then `segment`=4'b1110 and `display`=~digit0 for 14 clocks.
2. Scan order: digits 0x3F/0x06/0x5B/0x4F. Required response:
   - anodes go active 1110→1101→1011→0111 across consecutive 16-clock slots;
   - `frame_done` is high at cycle 64 only.
3. Latch stability: change digit 1's pattern mid-SHOW of slot 1. Required response: `display` stays unchanged until the slot 1 latch of the next frame.
4. Blink: `blink_en`=1, `blink_mask`=4'b0100. Required response:
   - digit 2 is lit during frames 0–1 and dark during frames 2–3;
   - `blink_phase` toggles every 128 clocks;
   - other digits are unaffected.
5. `En` freeze: drop `En` for 10 clocks mid-SHOW of digit 3. Required response:
   - outputs are off;
   - on resume, digit 3 finishes its remaining on-cycles;
   - total slot time = 16 + 10.
6. Async `Clr` mid-SHOW of digit 2. Required response:
   - outputs are all-off in the same cycle, without waiting for a clock edge;
   - after release, the scan restarts at digit 0 with `blink_phase`=0.
